// File: rtl/pe_dp_ctrl_gen.sv
// Datapath controller for one PE: walks W > S > C > M over a runtime tile config and drives
// the fetch / multiply / sum pipeline with psum read-after-write hazard stalls.
module pe_dp_ctrl_gen #(
    parameter int unsigned IP_DEPTH = 12,
    parameter int unsigned WP_DEPTH = 224,
    parameter int unsigned PP_DEPTH = 24,
    parameter int unsigned CNT_WD   = 8,
    parameter int unsigned IPA_WD   = $clog2(IP_DEPTH),
    parameter int unsigned WPA_WD   = $clog2(WP_DEPTH),
    parameter int unsigned PPA_WD   = $clog2(PP_DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_cfg_valid,
    output logic              o_cfg_ready,
    input  logic [CNT_WD-1:0] i_cfg_S,
    input  logic [CNT_WD-1:0] i_cfg_C,
    input  logic [CNT_WD-1:0] i_cfg_M,
    input  logic [CNT_WD-1:0] i_cfg_W,
    input  logic              i_cfg_acc,
    output logic              o_cfg_err,
    output logic              o_done,
    input  logic              i_win_valid,
    output logic              o_win_ready,
    output logic              o_fs_valid,
    output logic [IPA_WD-1:0] o_ip_addr,
    output logic [WPA_WD-1:0] o_wp_addr,
    output logic [PPA_WD-1:0] o_pp_raddr,
    output logic              o_fs_rd_psum,
    output logic              o_ms_valid,
    output logic              o_ss_valid,
    output logic [PPA_WD-1:0] o_pp_waddr,
    output logic              o_ss_init,
    output logic              o_ss_last,
    output logic              o_ss_fstpix,
    output logic              o_ss_lstpix,
    output logic              o_ss_sht
);

    localparam int unsigned PROD_WD = 3 * CNT_WD;
    localparam logic [CNT_WD-1:0] ONE = CNT_WD'(1);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    typedef struct packed {
        logic [CNT_WD-1:0] m;
        logic              init;
        logic              last;
        logic              fst;
        logic              lst;
        logic              sht;
    } op_t;

    state_e state_q, state_d;

    logic [CNT_WD-1:0] cfg_s_q, cfg_c_q, cfg_m_q, cfg_w_q;
    logic              cfg_acc_q;
    logic [CNT_WD-1:0] s_q, c_q, m_q, w_q;
    logic [CNT_WD-1:0] s_d, c_d, m_d, w_d;
    logic              err_q;

    logic              ms_valid_q, ss_valid_q;
    op_t               ms_q, ss_q, fs_op;

    logic [PROD_WD-1:0] in_sc, in_scm;
    logic               cfg_legal;
    logic               accept, hazard, issue, pipe_empty;
    logic               last_s, last_c, last_m, last_w, tile_end;

    // Legality is judged on the offered fields, so the reject pulse lands one cycle later.
    always_comb begin
        in_sc     = PROD_WD'(i_cfg_S) * PROD_WD'(i_cfg_C);
        in_scm    = in_sc * PROD_WD'(i_cfg_M);
        cfg_legal = (i_cfg_S != '0) && (i_cfg_C != '0) && (i_cfg_M != '0) && (i_cfg_W != '0) &&
                    (in_sc <= PROD_WD'(IP_DEPTH)) && (in_scm <= PROD_WD'(WP_DEPTH)) &&
                    (PROD_WD'(i_cfg_M) <= PROD_WD'(PP_DEPTH));
    end

    always_comb begin
        accept     = (state_q == StIdle) && i_cfg_valid;
        last_s     = (s_q == cfg_s_q - ONE);
        last_c     = (c_q == cfg_c_q - ONE);
        last_m     = (m_q == cfg_m_q - ONE);
        last_w     = (w_q == cfg_w_q - ONE);
        hazard     = (ms_valid_q && (ms_q.m == m_q)) || (ss_valid_q && (ss_q.m == m_q));
        issue      = (state_q == StRun) && i_win_valid && !hazard;
        pipe_empty = !ms_valid_q && !ss_valid_q;

        fs_op.m    = m_q;
        fs_op.init = (s_q == '0) && (c_q == '0) && !cfg_acc_q;
        fs_op.last = last_s && last_c;
        fs_op.fst  = (w_q == '0);
        fs_op.lst  = last_w;
        fs_op.sht  = last_s && last_c && last_m;
        tile_end   = fs_op.sht && last_w;
    end

    // FSM: state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept && cfg_legal) state_d = StRun;
            StRun:   if (issue && tile_end) state_d = StDrain;
            StDrain: if (pipe_empty) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM: outputs; done fires the cycle after the final writeback has left SS.
    always_comb begin
        o_cfg_ready  = (state_q == StIdle);
        o_cfg_err    = err_q;
        o_done       = err_q || ((state_q == StDrain) && pipe_empty);
        o_fs_valid   = issue;
        o_fs_rd_psum = issue && !fs_op.init;
        o_ip_addr    = IPA_WD'(PROD_WD'(s_q) * PROD_WD'(cfg_c_q) + PROD_WD'(c_q));
        o_wp_addr    = WPA_WD'((PROD_WD'(s_q) * PROD_WD'(cfg_c_q) + PROD_WD'(c_q)) *
                               PROD_WD'(cfg_m_q) + PROD_WD'(m_q));
        o_pp_raddr   = PPA_WD'(m_q);
    end

    always_comb begin
        s_d = s_q;
        c_d = c_q;
        m_d = m_q;
        w_d = w_q;
        if (accept) begin
            s_d = '0;
            c_d = '0;
            m_d = '0;
            w_d = '0;
        end else if (issue) begin
            if (!last_m) begin
                m_d = m_q + ONE;
            end else begin
                m_d = '0;
                if (!last_c) begin
                    c_d = c_q + ONE;
                end else begin
                    c_d = '0;
                    if (!last_s) begin
                        s_d = s_q + ONE;
                    end else begin
                        s_d = '0;
                        w_d = last_w ? '0 : w_q + ONE;
                    end
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cfg_s_q   <= '0;
            cfg_c_q   <= '0;
            cfg_m_q   <= '0;
            cfg_w_q   <= '0;
            cfg_acc_q <= 1'b0;
            err_q     <= 1'b0;
            s_q       <= '0;
            c_q       <= '0;
            m_q       <= '0;
            w_q       <= '0;
        end else begin
            err_q <= accept && !cfg_legal;
            if (accept) begin
                cfg_s_q   <= i_cfg_S;
                cfg_c_q   <= i_cfg_C;
                cfg_m_q   <= i_cfg_M;
                cfg_w_q   <= i_cfg_W;
                cfg_acc_q <= i_cfg_acc;
            end
            s_q <= s_d;
            c_q <= c_d;
            m_q <= m_d;
            w_q <= w_d;
        end
    end

    // Fixed-latency pipeline; sideband is zeroed on bubbles so outputs need no extra gating.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ms_valid_q <= 1'b0;
            ss_valid_q <= 1'b0;
            ms_q       <= '0;
            ss_q       <= '0;
        end else begin
            ms_valid_q <= issue;
            ms_q       <= issue ? fs_op : '0;
            ss_valid_q <= ms_valid_q;
            ss_q       <= ms_q;
        end
    end

    always_comb begin
        o_ms_valid  = ms_valid_q;
        o_ss_valid  = ss_valid_q;
        o_pp_waddr  = PPA_WD'(ss_q.m);
        o_ss_init   = ss_q.init;
        o_ss_last   = ss_q.last;
        o_ss_fstpix = ss_q.fst;
        o_ss_lstpix = ss_q.lst;
        o_ss_sht    = ss_q.sht;
        o_win_ready = ss_q.sht;
    end

endmodule

// File: tb/tb_pe_dp_ctrl_gen.sv
// Self-checking bench for pe_dp_ctrl_gen: a loop-nest model fills FS/SS scoreboards at config
// time and every issued / written-back op is popped and compared.
module tb_pe_dp_ctrl_gen;

    logic       clk, rst_n;
    logic       cfg_valid, cfg_ready, cfg_acc, cfg_err, done;
    logic [7:0] cfg_s, cfg_c, cfg_m, cfg_w;
    logic       win_valid, win_ready;
    logic       fs_valid, rd_psum, ms_valid, ss_valid;
    logic [3:0] ip_addr;
    logic [7:0] wp_addr;
    logic [4:0] pp_raddr, pp_waddr;
    logic       ss_init, ss_last, ss_fst, ss_lst, ss_sht;

    pe_dp_ctrl_gen dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_cfg_valid  (cfg_valid),
        .o_cfg_ready  (cfg_ready),
        .i_cfg_S      (cfg_s),
        .i_cfg_C      (cfg_c),
        .i_cfg_M      (cfg_m),
        .i_cfg_W      (cfg_w),
        .i_cfg_acc    (cfg_acc),
        .o_cfg_err    (cfg_err),
        .o_done       (done),
        .i_win_valid  (win_valid),
        .o_win_ready  (win_ready),
        .o_fs_valid   (fs_valid),
        .o_ip_addr    (ip_addr),
        .o_wp_addr    (wp_addr),
        .o_pp_raddr   (pp_raddr),
        .o_fs_rd_psum (rd_psum),
        .o_ms_valid   (ms_valid),
        .o_ss_valid   (ss_valid),
        .o_pp_waddr   (pp_waddr),
        .o_ss_init    (ss_init),
        .o_ss_last    (ss_last),
        .o_ss_fstpix  (ss_fst),
        .o_ss_lstpix  (ss_lst),
        .o_ss_sht     (ss_sht)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] ip;
        logic [7:0] wp;
        logic [4:0] pp;
        logic       rd;
    } fs_exp_t;

    typedef struct packed {
        logic [4:0] m;
        logic       init;
        logic       last;
        logic       fst;
        logic       lst;
        logic       sht;
    } ss_exp_t;

    typedef struct packed {
        int fs_cnt;
        int first_fs;
        int last_fs;
        int first_ss;
        int done_cyc;
        int init_cnt;
        int last_cnt;
        int sht_cnt;
        int rd_cnt;
    } stats_t;

    fs_exp_t fs_sb[$];
    ss_exp_t ss_sb[$];
    int      passed = 0;
    int      total  = 0;

    task automatic build_model(input int s_n, input int c_n, input int m_n, input int w_n,
                               input bit acc);
        fs_exp_t fe;
        ss_exp_t se;
        for (int wi = 0; wi < w_n; wi++)
            for (int si = 0; si < s_n; si++)
                for (int ci = 0; ci < c_n; ci++)
                    for (int mi = 0; mi < m_n; mi++) begin
                        se.m    = 5'(mi);
                        se.init = (si == 0) && (ci == 0) && !acc;
                        se.last = (si == s_n - 1) && (ci == c_n - 1);
                        se.sht  = se.last && (mi == m_n - 1);
                        se.fst  = (wi == 0);
                        se.lst  = (wi == w_n - 1);
                        fe.ip   = 4'(si * c_n + ci);
                        fe.wp   = 8'((si * c_n + ci) * m_n + mi);
                        fe.pp   = 5'(mi);
                        fe.rd   = !se.init;
                        fs_sb.push_back(fe);
                        ss_sb.push_back(se);
                    end
    endtask

    // Drives one tile and checks every FS/SS op against the scoreboard; cycle 0 is the first
    // cycle in RUN.
    task automatic run_tile(input int s_n, input int c_n, input int m_n, input int w_n,
                            input bit acc, input int pause_at, input int pause_len,
                            input bit hold_cfg, output stats_t st);
        fs_exp_t fe;
        ss_exp_t se;
        int      cyc, pause_left;
        bit      done_seen, paused, err_seen;
        st         = '0;
        st.first_fs = -1;
        st.first_ss = -1;
        st.done_cyc = -1;
        pause_left = 0;
        paused     = 0;
        done_seen  = 0;
        err_seen   = 0;
        @(negedge clk);
        total++;
        if (cfg_ready !== 1'b1) $display("FAIL cfg_ready_idle got %b want 1", cfg_ready);
        else passed++;
        build_model(s_n, c_n, m_n, w_n, acc);
        cfg_s = 8'(s_n); cfg_c = 8'(c_n); cfg_m = 8'(m_n); cfg_w = 8'(w_n);
        cfg_acc   = acc;
        cfg_valid = 1'b1;
        win_valid = 1'b1;
        @(negedge clk);
        if (hold_cfg) begin
            cfg_s = 8'd4; cfg_c = 8'd0; cfg_m = 8'd99; cfg_w = 8'd1; cfg_acc = ~acc;
        end else begin
            cfg_valid = 1'b0;
        end
        cyc = 0;
        while (!done_seen && cyc < 2000) begin
            if (cfg_err) err_seen = 1;
            if (fs_valid) begin
                total++;
                if (fs_sb.size() == 0) begin
                    $display("FAIL fs_extra cycle %0d got issue want none", cyc);
                end else begin
                    fe = fs_sb.pop_front();
                    if ({ip_addr, wp_addr, pp_raddr, rd_psum} !== fe)
                        $display("FAIL fs_op[%0d] got ip=%0d wp=%0d pp=%0d rd=%b want ip=%0d wp=%0d pp=%0d rd=%b",
                                 st.fs_cnt, ip_addr, wp_addr, pp_raddr, rd_psum,
                                 fe.ip, fe.wp, fe.pp, fe.rd);
                    else passed++;
                end
                if (st.first_fs < 0) st.first_fs = cyc;
                st.last_fs = cyc;
                st.fs_cnt++;
                if (rd_psum) st.rd_cnt++;
            end
            if (ss_valid) begin
                total++;
                if (ss_sb.size() == 0) begin
                    $display("FAIL ss_extra cycle %0d got write want none", cyc);
                end else begin
                    se = ss_sb.pop_front();
                    if ({pp_waddr, ss_init, ss_last, ss_fst, ss_lst, ss_sht, win_ready} !==
                        {se, se.sht})
                        $display("FAIL ss_op cycle %0d got m=%0d i/l/f/l/s/wr=%b%b%b%b%b%b want m=%0d %b%b%b%b%b%b",
                                 cyc, pp_waddr, ss_init, ss_last, ss_fst, ss_lst, ss_sht,
                                 win_ready, se.m, se.init, se.last, se.fst, se.lst, se.sht,
                                 se.sht);
                    else passed++;
                end
                if (st.first_ss < 0) st.first_ss = cyc;
                if (ss_init) st.init_cnt++;
                if (ss_last) st.last_cnt++;
                if (ss_sht) st.sht_cnt++;
            end
            if (done) begin
                done_seen   = 1;
                st.done_cyc = cyc;
                cfg_valid   = 1'b0;
            end else begin
                if (pause_at >= 0 && !paused && st.fs_cnt == pause_at) begin
                    paused     = 1;
                    pause_left = pause_len;
                    win_valid  = 1'b0;
                end else if (pause_left > 0) begin
                    pause_left--;
                    if (pause_left == 0) win_valid = 1'b1;
                end
                cyc++;
                @(negedge clk);
            end
        end
        win_valid = 1'b0;
        total++;
        if (!done_seen) $display("FAIL done_timeout got no done want done within 2000 cycles");
        else passed++;
        total++;
        if (fs_sb.size() != 0 || ss_sb.size() != 0)
            $display("FAIL sb_drain got fs_left=%0d ss_left=%0d want 0/0", fs_sb.size(),
                     ss_sb.size());
        else passed++;
        total++;
        if (err_seen) $display("FAIL err_in_run got cfg_err=1 want 0");
        else passed++;
        fs_sb.delete();
        ss_sb.delete();
    endtask

    task automatic test_reset();
        bit bad;
        rst_n = 1'b0; cfg_valid = 1'b0; win_valid = 1'b0; cfg_acc = 1'b0;
        cfg_s = '0; cfg_c = '0; cfg_m = '0; cfg_w = '0;
        repeat (2) @(negedge clk);
        total++;
        if ({fs_valid, ms_valid, ss_valid, done, cfg_err, cfg_ready, ip_addr, wp_addr, pp_raddr,
             pp_waddr} !== {5'b00000, 1'b1, 22'd0})
            $display("FAIL reset_state got v=%b%b%b d=%b e=%b r=%b ip=%0d wp=%0d want 000 0 0 1 0 0",
                     fs_valid, ms_valid, ss_valid, done, cfg_err, cfg_ready, ip_addr, wp_addr);
        else passed++;
        rst_n = 1'b1;
        @(negedge clk);
        cfg_s = 8'd3; cfg_c = 8'd2; cfg_m = 8'd4; cfg_w = 8'd2; cfg_valid = 1'b1;
        win_valid = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
        repeat (10) @(negedge clk);
        total++;
        if ({fs_valid, ms_valid, ss_valid} !== 3'b111)
            $display("FAIL reset_prerun got v=%b%b%b want 111", fs_valid, ms_valid, ss_valid);
        else passed++;
        rst_n = 1'b0;
        #1;
        total++;
        if ({fs_valid, ms_valid, ss_valid, done, cfg_ready} !== 5'b00001)
            $display("FAIL reset_midrun got v=%b%b%b d=%b r=%b want 000 0 1", fs_valid,
                     ms_valid, ss_valid, done, cfg_ready);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (60) begin
            @(negedge clk);
            if (done || fs_valid || !cfg_ready) bad = 1;
        end
        win_valid = 1'b0;
        total++;
        if (bad) $display("FAIL reset_abort got done/issue/not-ready after reset want idle");
        else passed++;
    endtask

    task automatic test_basic();
        stats_t st;
        run_tile(3, 2, 4, 2, 0, -1, 0, 0, st);
        total++;
        if ({st.fs_cnt, st.first_fs, st.last_fs} !== {32'd48, 32'd0, 32'd47})
            $display("FAIL basic_issue got cnt=%0d first=%0d last=%0d want 48/0/47", st.fs_cnt,
                     st.first_fs, st.last_fs);
        else passed++;
        total++;
        if ({st.init_cnt, st.last_cnt, st.sht_cnt} !== {32'd8, 32'd8, 32'd2})
            $display("FAIL basic_side got init=%0d last=%0d sht=%0d want 8/8/2", st.init_cnt,
                     st.last_cnt, st.sht_cnt);
        else passed++;
        total++;
        if (st.done_cyc !== st.last_fs + 3)
            $display("FAIL basic_done got %0d want %0d", st.done_cyc, st.last_fs + 3);
        else passed++;
    endtask

    task automatic test_hazard();
        stats_t st;
        run_tile(2, 1, 1, 1, 0, -1, 0, 0, st);
        total++;
        if ({st.fs_cnt, st.first_fs, st.last_fs, st.first_ss} !== {32'd2, 32'd0, 32'd3, 32'd2})
            $display("FAIL m1_timing got cnt=%0d first=%0d last=%0d ss=%0d want 2/0/3/2",
                     st.fs_cnt, st.first_fs, st.last_fs, st.first_ss);
        else passed++;
        run_tile(1, 2, 2, 1, 0, -1, 0, 0, st);
        total++;
        if ({st.fs_cnt, st.last_fs} !== {32'd4, 32'd4})
            $display("FAIL m2_timing got cnt=%0d last=%0d want 4/4", st.fs_cnt, st.last_fs);
        else passed++;
        run_tile(12, 1, 1, 1, 0, -1, 0, 0, st);
        total++;
        if ({st.fs_cnt, st.last_fs, st.done_cyc} !== {32'd12, 32'd33, 32'd36})
            $display("FAIL ip_bound got cnt=%0d last=%0d done=%0d want 12/33/36", st.fs_cnt,
                     st.last_fs, st.done_cyc);
        else passed++;
    endtask

    task automatic test_illegal(input int s_n, input int c_n, input int m_n, input int w_n);
        bit bad;
        @(negedge clk);
        cfg_s = 8'(s_n); cfg_c = 8'(c_n); cfg_m = 8'(m_n); cfg_w = 8'(w_n);
        cfg_valid = 1'b1;
        win_valid = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
        total++;
        if ({cfg_err, done, fs_valid, cfg_ready} !== 4'b1101)
            $display("FAIL illegal_%0d_%0d_%0d got err=%b done=%b fs=%b rdy=%b want 1 1 0 1",
                     s_n, c_n, m_n, cfg_err, done, fs_valid, cfg_ready);
        else passed++;
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (cfg_err || done || fs_valid || !cfg_ready) bad = 1;
        end
        win_valid = 1'b0;
        total++;
        if (bad) $display("FAIL illegal_after got activity want idle");
        else passed++;
    endtask

    task automatic test_acc();
        stats_t st;
        run_tile(2, 2, 3, 1, 1, -1, 0, 0, st);
        total++;
        if ({st.init_cnt, st.rd_cnt, st.fs_cnt, st.last_fs} !==
            {32'd0, 32'd12, 32'd12, 32'd11})
            $display("FAIL acc got init=%0d rd=%0d cnt=%0d last=%0d want 0/12/12/11",
                     st.init_cnt, st.rd_cnt, st.fs_cnt, st.last_fs);
        else passed++;
    endtask

    task automatic test_win_pause();
        stats_t st;
        run_tile(3, 2, 4, 2, 0, 10, 5, 0, st);
        total++;
        if ({st.fs_cnt, st.last_fs, st.done_cyc} !== {32'd48, 32'd52, 32'd55})
            $display("FAIL win_pause got cnt=%0d last=%0d done=%0d want 48/52/55", st.fs_cnt,
                     st.last_fs, st.done_cyc);
        else passed++;
    endtask

    task automatic test_back_to_back();
        stats_t st;
        // Weight pad filled to 216 of 224 while junk config is held on the offer lines.
        run_tile(3, 4, 18, 1, 0, -1, 0, 1, st);
        total++;
        if ({st.fs_cnt, st.last_fs, st.sht_cnt} !== {32'd216, 32'd215, 32'd1})
            $display("FAIL wp_bound got cnt=%0d last=%0d sht=%0d want 216/215/1", st.fs_cnt,
                     st.last_fs, st.sht_cnt);
        else passed++;
        run_tile(1, 1, 24, 3, 0, -1, 0, 0, st);
        total++;
        if ({st.fs_cnt, st.last_fs, st.init_cnt} !== {32'd72, 32'd71, 32'd72})
            $display("FAIL pp_bound got cnt=%0d last=%0d init=%0d want 72/71/72", st.fs_cnt,
                     st.last_fs, st.init_cnt);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hazard();
        test_illegal(2, 0, 2, 2);
        test_illegal(4, 4, 1, 1);
        test_illegal(1, 1, 25, 1);
        test_illegal(2, 6, 19, 1);
        test_acc();
        test_win_pause();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
